// File: rtl/board_pkg.sv
// Shared types and widths for the board sequencer.
package board_pkg;

    localparam int BOARD_MIN = 1;
    localparam int BOARD_W   = 3;
    localparam int FADE_W    = 4;

    typedef enum logic [2:0] {
        IDLE,
        FADE_OUT,
        SWITCH,
        FADE_IN,
        WIN
    } state_e;

endpackage

// File: rtl/frame_tick.sv
// Registers vertical blank and flags the first clock of each blanking interval.
module frame_tick (
    input  logic clk,
    input  logic reset,
    input  logic vblnk_in,
    output logic frame_start
);

    logic vblnk_q;

    always_ff @(posedge clk) begin
        if (!reset) begin
            vblnk_q <= 1'b0;
        end else begin
            vblnk_q <= vblnk_in;
        end
    end

    assign frame_start = vblnk_in & ~vblnk_q;

endmodule

// File: rtl/board_sequencer.sv
// Board selection and fade-out/switch/fade-in transition sequencer.
// Macro BOARD_FADE_EN builds the fade ramps; without it boards switch instantly.
module board_sequencer
    import board_pkg::*;
#(
    parameter int BOARD_MAX   = 5,
    parameter int BOARD_START = 3
`ifdef BOARD_FADE_EN
    ,
    parameter int FADE_STEPS  = 8
`endif
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       vblnk_in,
    input  logic       req_left,
    input  logic       req_right,
    output logic [2:0] board_out,
    output logic [3:0] fade_level,
    output logic       busy,
    output logic       respawn,
    output logic [1:0] winner
);

    localparam logic [3:0] MIN4   = 4'(BOARD_MIN);
    localparam logic [3:0] MAX4   = 4'(BOARD_MAX);
    localparam logic [2:0] START3 = 3'(BOARD_START);
`ifdef BOARD_FADE_EN
    localparam logic [3:0] RAMP_TOP = 4'(FADE_STEPS - 1);
`endif

    state_e     state_q;
    logic [2:0] board_q;
    logic [2:0] target_q;
    logic       pend_l_q;
    logic       pend_r_q;
    logic       busy_q;
    logic       respawn_q;
    logic [1:0] winner_q;
`ifdef BOARD_FADE_EN
    logic [3:0] fade_q;
`endif

    logic       frame_start;
    logic       move_l;
    logic       move_r;
    logic [3:0] board_ext;
    logic [3:0] target_d;
    logic       target_ok;

    frame_tick u_frame_tick (
        .clk         (clk),
        .reset       (reset),
        .vblnk_in    (vblnk_in),
        .frame_start (frame_start)
    );

    // Simultaneous left and right requests cancel each other out.
    assign move_r    = pend_r_q & ~pend_l_q;
    assign move_l    = pend_l_q & ~pend_r_q;
    assign board_ext = {1'b0, board_q};
    assign target_d  = move_r ? board_ext + 4'd1 : board_ext - 4'd1;
    assign target_ok = (target_d >= MIN4) && (target_d <= MAX4);

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q   <= IDLE;
            board_q   <= START3;
            target_q  <= START3;
            pend_l_q  <= 1'b0;
            pend_r_q  <= 1'b0;
            busy_q    <= 1'b0;
            respawn_q <= 1'b0;
            winner_q  <= 2'b00;
`ifdef BOARD_FADE_EN
            fade_q    <= 4'd0;
`endif
        end else begin
            respawn_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (frame_start) begin
                        pend_l_q <= 1'b0;
                        pend_r_q <= 1'b0;
                        if (move_r && board_ext == MAX4) begin
                            winner_q[0] <= 1'b1;
                            state_q     <= WIN;
                        end else if (move_l && board_ext == MIN4) begin
                            winner_q[1] <= 1'b1;
                            state_q     <= WIN;
                        end else if ((move_r || move_l) && target_ok) begin
                            target_q <= target_d[2:0];
                            busy_q   <= 1'b1;
`ifdef BOARD_FADE_EN
                            state_q  <= FADE_OUT;
`else
                            state_q  <= SWITCH;
`endif
                        end
                    end else begin
                        pend_l_q <= pend_l_q | req_left;
                        pend_r_q <= pend_r_q | req_right;
                    end
                end
`ifdef BOARD_FADE_EN
                FADE_OUT: begin
                    if (frame_start) begin
                        if (fade_q == RAMP_TOP) begin
                            state_q <= SWITCH;
                        end else begin
                            fade_q <= fade_q + 4'd1;
                        end
                    end
                end
`endif
                SWITCH: begin
                    board_q   <= target_q;
                    respawn_q <= 1'b1;
`ifdef BOARD_FADE_EN
                    state_q   <= FADE_IN;
`else
                    state_q   <= IDLE;
                    busy_q    <= 1'b0;
`endif
                end
`ifdef BOARD_FADE_EN
                FADE_IN: begin
                    if (frame_start) begin
                        fade_q <= fade_q - 4'd1;
                        if (fade_q == 4'd1) begin
                            state_q <= IDLE;
                            busy_q  <= 1'b0;
                        end
                    end
                end
`endif
                WIN: begin
                    state_q <= WIN;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign board_out = board_q;
    assign busy      = busy_q;
    assign respawn   = respawn_q;
    assign winner    = winner_q;
`ifdef BOARD_FADE_EN
    assign fade_level = fade_q;
`else
    assign fade_level = 4'd0;
`endif

endmodule

// File: tb/tb_board_sequencer.sv
// Randomized frame-level bench for board_sequencer with a transition-schedule reference model.
`timescale 1ns/1ps
module tb_board_sequencer;

    localparam int BOARD_MAX   = 5;
    localparam int BOARD_START = 3;
    localparam int FADE_STEPS  = 8;
`ifdef BOARD_FADE_EN
    localparam bit FADE = 1'b1;
`else
    localparam bit FADE = 1'b0;
`endif
    localparam int RAMP     = FADE_STEPS - 1;
    localparam int TOTAL    = 2 * RAMP + 1;
    localparam int LOW_CYC  = 5;
    localparam int HIGH_CYC = 3;

    logic       clk       = 1'b0;
    logic       reset     = 1'b0;
    logic       vblnk_in  = 1'b0;
    logic       req_left  = 1'b0;
    logic       req_right = 1'b0;
    logic [2:0] board_out;
    logic [3:0] fade_level;
    logic       busy;
    logic       respawn;
    logic [1:0] winner;

    int errors      = 0;
    int checks      = 0;
    int pulses_seen = 0;
    int pulses_exp  = 0;
    int frame_no    = 0;

    // Reference model: board, sticky winner, pending requests and the
    // number of frames elapsed since a transition was decided (-1 = none).
    int       m_board;
    int       m_target;
    int       m_n;
    bit       m_pl;
    bit       m_pr;
    bit [1:0] m_win;

    always #5 clk = ~clk;

    board_sequencer dut (
        .clk        (clk),
        .reset      (reset),
        .vblnk_in   (vblnk_in),
        .req_left   (req_left),
        .req_right  (req_right),
        .board_out  (board_out),
        .fade_level (fade_level),
        .busy       (busy),
        .respawn    (respawn),
        .winner     (winner)
    );

    always @(negedge clk) begin
        if (reset && respawn) pulses_seen++;
    end

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s frame=%0d got=%0d expected=%0d", tag, frame_no, got, exp);
        end
    endtask

    task automatic model_reset();
        m_board = BOARD_START;
        m_target = BOARD_START;
        m_n = -1;
        m_pl = 1'b0;
        m_pr = 1'b0;
        m_win = 2'b00;
    endtask

    function automatic int exp_fade();
        if (!FADE || m_n < 0) return 0;
        return (m_n < TOTAL - m_n) ? m_n : TOTAL - m_n;
    endfunction

    // Effect of one frame start on the model; sw reports a board switch in this frame.
    task automatic model_frame(output bit sw);
        sw = 1'b0;
        if (m_win != 2'b00) return;
        if (m_n < 0) begin
            if (m_pl ^ m_pr) begin
                if (m_pr && m_board == BOARD_MAX) m_win[0] = 1'b1;
                else if (m_pl && m_board == 1) m_win[1] = 1'b1;
                else begin
                    m_target = m_pr ? m_board + 1 : m_board - 1;
                    if (FADE) m_n = 0;
                    else sw = 1'b1;
                end
            end
            m_pl = 1'b0;
            m_pr = 1'b0;
        end else begin
            m_n++;
            if (m_n == RAMP + 1) sw = 1'b1;
            if (m_n == TOTAL) m_n = -1;
        end
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_board"}, board_out, BOARD_START);
        check({tag, "_fade"}, fade_level, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_respawn"}, respawn, 0);
        check({tag, "_winner"}, winner, 0);
    endtask

    // One frame: low blanking-free phase carrying requests, then vblank high.
    task automatic run_frame(input bit rl, input bit rr, input bit rst_mid);
        int pos_l;
        int pos_r;
        int old_board;
        bit sw;
        pos_l = $urandom_range(0, LOW_CYC - 1);
        pos_r = $urandom_range(0, LOW_CYC - 1);
        for (int c = 0; c < LOW_CYC; c++) begin
            vblnk_in  = 1'b0;
            req_left  = rl && !rst_mid && (c == pos_l);
            req_right = rr && !rst_mid && (c == pos_r);
            if (rst_mid && c == 1) reset = 1'b0;
            if (m_n < 0 && m_win == 2'b00) begin
                if (req_left) m_pl = 1'b1;
                if (req_right) m_pr = 1'b1;
            end
            @(negedge clk);
            if (rst_mid && c == 1) begin
                reset = 1'b1;
                model_reset();
                check_reset_state("midrst");
            end
        end
        req_left  = 1'b0;
        req_right = 1'b0;
        vblnk_in  = 1'b1;
        old_board = m_board;
        model_frame(sw);
        @(negedge clk);
        check("busy_a", busy, FADE ? (m_n >= 0) : sw);
        check("fade_a", fade_level, exp_fade());
        check("board_a", board_out, old_board);
        check("respawn_a", respawn, 0);
        check("winner", winner, m_win);
        if (sw) begin
            m_board = m_target;
            pulses_exp++;
        end
        @(negedge clk);
        check("busy_b", busy, FADE ? (m_n >= 0) : 0);
        check("fade_b", fade_level, exp_fade());
        check("board_b", board_out, m_board);
        check("respawn_b", respawn, sw);
        for (int c = 2; c < HIGH_CYC; c++) @(negedge clk);
        $display("frame %0d req=%0d%0d rst=%0d board=%0d fade=%0d busy=%0d winner=%0d",
                 frame_no, rl, rr, rst_mid, board_out, fade_level, busy, winner);
        frame_no++;
    endtask

    // Idle frames until the model's transition finishes; right requests during fade-in are noise.
    task automatic settle();
        for (int k = 0; k < TOTAL + 2 && m_n >= 0; k++) begin
            run_frame(1'b0, m_n > RAMP, 1'b0);
        end
    endtask

    initial begin
        int r;
        model_reset();
        reset = 1'b0;
        repeat (3) @(negedge clk);
        check_reset_state("reset");
        reset = 1'b1;

        run_frame(1'b0, 1'b0, 1'b0);
        run_frame(1'b0, 1'b1, 1'b0);   // 3 -> 4
        settle();
        run_frame(1'b1, 1'b1, 1'b0);   // cancel
        run_frame(1'b0, 1'b0, 1'b0);
        run_frame(1'b0, 1'b1, 1'b0);   // 4 -> 5
        settle();
        run_frame(1'b0, 1'b1, 1'b0);   // exit right end
        run_frame(1'b1, 1'b0, 1'b0);
        run_frame(1'b0, 1'b1, 1'b0);
        run_frame(1'b0, 1'b0, 1'b1);   // reset out of WIN
        run_frame(1'b0, 1'b1, 1'b0);
        while (FADE && m_n >= 0 && m_n < 4) run_frame(1'b0, 1'b0, 1'b0);
        run_frame(1'b0, 1'b0, 1'b1);   // reset mid fade-out
        run_frame(1'b1, 1'b0, 1'b0);   // 3 -> 2
        settle();
        run_frame(1'b1, 1'b0, 1'b0);   // 2 -> 1
        settle();
        run_frame(1'b1, 1'b0, 1'b0);   // exit left end
        run_frame(1'b0, 1'b0, 1'b0);
        run_frame(1'b0, 1'b0, 1'b1);

        for (int f = 0; f < 250; f++) begin
            r = $urandom_range(0, 9);
            case (r)
                4, 5:    run_frame(1'b1, 1'b0, 1'b0);
                6, 7:    run_frame(1'b0, 1'b1, 1'b0);
                8:       run_frame(1'b1, 1'b1, 1'b0);
                9:       run_frame(1'b0, 1'b0, m_win != 2'b00);
                default: run_frame(1'b0, 1'b0, 1'b0);
            endcase
        end

        check("respawn_total", pulses_seen, pulses_exp);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
